// File: rtl/debounce_pkg.sv
// Shared types for the debounce/event-counter slice.
// State encoding and width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_event_counter_if.sv
// Input level/clear and debounced outputs of
// the debounce event counter.
interface debounce_event_counter_if #(
  parameter int EVT_CNT_W = 8
) ();

  logic                 sync_in;
  logic                 clr_count;
  logic                 db_out;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic                 glitch_pulse;
  logic                 busy;
  logic [EVT_CNT_W-1:0] event_count;

  modport master (
    output sync_in,
    output clr_count,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  glitch_pulse,
    input  busy,
    input  event_count
  );

  modport slave (
    input  sync_in,
    input  clr_count,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output glitch_pulse,
    output busy,
    output event_count
  );

endinterface

// File: rtl/debounce_timer.sv
// Stability counter: start loads 1, clear zeroes,
// inc advances; done flags the final sample.
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int LW = clog2(STABLE_CYCLES);
  localparam int CW = (LW < 1) ? 1 : LW;
  localparam logic [CW-1:0] LAST =
    CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/debounce_event_counter.sv
// Debounces a synchronized level, emits edge and glitch
// pulses and counts debounced rising events.
module debounce_event_counter
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int EVT_CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  debounce_event_counter_if.slave  bus
);

  if (STABLE_CYCLES < 2) begin : g_bad_param
    $error("STABLE_CYCLES must be >= 2");
  end

  state_t               state;
  logic                 db;
  logic                 rise;
  logic                 fall;
  logic                 glitch;
  logic                 busy_q;
  logic [EVT_CNT_W-1:0] count;

  logic s;
  logic clr;
  logic start;
  logic clear;
  logic inc;
  logic done;

  assign s   = bus.sync_in;
  assign clr = bus.clr_count;

  always_comb begin
    start = 1'b0;
    clear = 1'b0;
    inc   = 1'b0;
    unique case (state)
      IDLE_LOW:  start = s;
      IDLE_HIGH: start = !s;
      CHK_HIGH: begin
        clear = !s || done;
        inc   = s && !done;
      end
      CHK_LOW: begin
        clear = s || done;
        inc   = !s && !done;
      end
    endcase
  end

  debounce_timer #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .inc     (inc),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE_LOW;
      db     <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      busy_q <= 1'b0;
      count  <= '0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      if (clr) count <= '0;
      unique case (state)
        IDLE_LOW: begin
          if (s) begin
            state  <= CHK_HIGH;
            busy_q <= 1'b1;
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            state  <= IDLE_LOW;
            busy_q <= 1'b0;
            glitch <= 1'b1;
          end else if (done) begin
            state  <= IDLE_HIGH;
            busy_q <= 1'b0;
            db     <= 1'b1;
            rise   <= 1'b1;
            // a coincident clear still keeps this event
            count  <= clr ? EVT_CNT_W'(1)
                          : count + EVT_CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state  <= CHK_LOW;
            busy_q <= 1'b1;
          end
        end
        CHK_LOW: begin
          if (s) begin
            state  <= IDLE_HIGH;
            busy_q <= 1'b0;
            glitch <= 1'b1;
          end else if (done) begin
            state  <= IDLE_LOW;
            busy_q <= 1'b0;
            db     <= 1'b0;
            fall   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.db_out       = db;
  assign bus.rise_pulse   = rise;
  assign bus.fall_pulse   = fall;
  assign bus.glitch_pulse = glitch;
  assign bus.busy         = busy_q;
  assign bus.event_count  = count;

endmodule

// File: tb/tb_debounce_event_counter.sv
// Directed and random checks of the debounce event
// counter against a run-length reference model.
module tb_debounce_event_counter;

  localparam int SC = 4;
  localparam int W  = 8;

  logic clk;
  logic reset_n;

  debounce_event_counter_if #(.EVT_CNT_W(W)) bus ();

  debounce_event_counter #(
    .STABLE_CYCLES (SC),
    .EVT_CNT_W     (W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Model: db level plus the length of the current run
  // of samples that disagree with it.
  logic m_db;
  int   m_run;
  int   m_cnt;
  logic m_rise;
  logic m_fall;
  logic m_glitch;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic model(input logic s,
                       input logic c,
                       input logic r);
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_glitch = 1'b0;
    if (!r) begin
      m_db  = 1'b0;
      m_run = 0;
      m_cnt = 0;
    end else begin
      if (s != m_db) begin
        m_run++;
        if (m_run == SC) begin
          m_db  = s;
          m_run = 0;
          m_rise = s;
          m_fall = !s;
        end
      end else begin
        m_glitch = (m_run > 0);
        m_run = 0;
      end
      if (m_rise)
        m_cnt = c ? 1 : (m_cnt + 1) % (1 << W);
      else if (c)
        m_cnt = 0;
    end
  endtask

  task automatic step(input logic s,
                      input logic c,
                      input logic r);
    logic [12:0] o;
    logic [12:0] e;
    @(negedge clk);
    bus.sync_in   = s;
    bus.clr_count = c;
    reset_n       = r;
    @(posedge clk);
    #1;
    model(s, c, r);
    o = {bus.db_out, bus.rise_pulse, bus.fall_pulse,
         bus.glitch_pulse, bus.busy, bus.event_count};
    e = {m_db, m_rise, m_fall, m_glitch,
         (m_run > 0), m_cnt[7:0]};
    check("outs", {19'd0, o}, {19'd0, e});
  endtask

  task automatic event_pair();
    for (int i = 0; i < SC; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < SC; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_db = 0; m_run = 0; m_cnt = 0;
    bus.sync_in   = 1'b1;
    bus.clr_count = 1'b0;
    reset_n       = 1'b0;

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_db", 32'(bus.db_out), 32'd0);
    check("rst_cnt", 32'(bus.event_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    step(1'b1, 1'b0, 1'b1);
    check("busy1", 32'(bus.busy), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("db3", 32'(bus.db_out), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("db4", 32'(bus.db_out), 32'd1);
    check("rise4", 32'(bus.rise_pulse), 32'd1);
    check("cnt4", 32'(bus.event_count), 32'd1);
    check("busy4", 32'(bus.busy), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("rise_1cyc", 32'(bus.rise_pulse), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("fall_db", 32'(bus.db_out), 32'd0);
    check("fall4", 32'(bus.fall_pulse), 32'd1);
    check("fall_rise", 32'(bus.rise_pulse), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("gl_pulse", 32'(bus.glitch_pulse), 32'd1);
    check("gl_db", 32'(bus.db_out), 32'd0);
    check("gl_cnt", 32'(bus.event_count), 32'd1);
    check("gl_busy", 32'(bus.busy), 32'd0);

    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 255; i++) event_pair();
    check("cnt_ff", 32'(bus.event_count), 32'hFF);
    event_pair();
    check("cnt_wrap", 32'(bus.event_count), 32'h00);

    for (int i = 0; i < SC - 1; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("clr_rise", 32'(bus.event_count), 32'd1);
    for (int i = 0; i < SC; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) event_pair();
    check("cnt5", 32'(bus.event_count), 32'd5);
    step(1'b0, 1'b1, 1'b1);
    check("clr_only", 32'(bus.event_count), 32'd0);

    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("mid_rst_db", 32'(bus.db_out), 32'd0);
    check("mid_rst_rise", 32'(bus.rise_pulse), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("fresh3", 32'(bus.db_out), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("fresh4", 32'(bus.db_out), 32'd1);

    for (int i = 0; i < 20; i++)
      step(logic'(i % 2 == 0), 1'b0, 1'b1);
    check("toggle_db", 32'(bus.db_out), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      logic s;
      logic c;
      logic r;
      s = ($urandom_range(0, 3) == 0) ? !bus.sync_in
                                        : bus.sync_in;
      c = ($urandom_range(0, 40) == 0);
      r = ($urandom_range(0, 300) != 0);
      step(s, c, r);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
